// File: rtl/msg_block_packer_if.sv
// Handshake bundle for msg_block_packer: 32-bit word input stream and padded 512-bit block output stream.
interface msg_block_packer_if;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         in_last;
  logic         in_ready;
  logic         blk_valid;
  logic [511:0] blk_data;
  logic         blk_last;
  logic         blk_ready;

  modport slave (
    input  in_valid, in_data, in_last, blk_ready,
    output in_ready, blk_valid, blk_data, blk_last
  );

  modport master (
    output in_valid, in_data, in_last, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_last
  );
endinterface

// File: rtl/msg_block_packer.sv
// Packs a 32-bit word message stream into 512-bit blocks with 0x80000000 marker,
// zero fill and trailing 64-bit bit length (SHA-2 style padding).
module msg_block_packer (
  input  logic                clk,
  input  logic                rst,
  msg_block_packer_if.slave   bus
);

  typedef enum logic [1:0] {
    FILL,
    EMIT,
    EMIT_EXTRA
  } state_e;

  localparam logic [31:0] MARKER = 32'h8000_0000;

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [15:0][31:0]  buf_q, buf_d;
  logic               last_q, last_d;
  logic               extra_q, extra_d;
  logic               marker_done_q, marker_done_d;

  logic [31:0]        cnt_inc;
  logic [63:0]        len_fill;
  logic [63:0]        len_held;

  function automatic logic [63:0] bit_len(input logic [31:0] words);
    return {27'b0, words, 5'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= FILL;
      idx_q         <= '0;
      cnt_q         <= '0;
      buf_q         <= '0;
      last_q        <= 1'b0;
      extra_q       <= 1'b0;
      marker_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      buf_q         <= buf_d;
      last_q        <= last_d;
      extra_q       <= extra_d;
      marker_done_q <= marker_done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    buf_d         = buf_q;
    last_d        = last_q;
    extra_d       = extra_q;
    marker_done_d = marker_done_q;
    cnt_inc       = cnt_q + 32'd1;
    len_fill      = bit_len(cnt_inc);
    len_held      = bit_len(cnt_q);

    case (state_q)
      FILL: begin
        if (bus.in_valid) begin
          cnt_d        = cnt_inc;
          buf_d[idx_q] = bus.in_data;
          idx_d        = idx_q + 4'd1;
          if (bus.in_last) begin
            idx_d   = '0;
            state_d = EMIT;
            // Everything above the last word is rewritten: marker right after it, zeros beyond.
            for (int unsigned i = 0; i < 16; i++) begin
              if (i > 32'(idx_q)) begin
                buf_d[i] = (i == 32'(idx_q) + 32'd1) ? MARKER : '0;
              end
            end
            if (idx_q <= 4'd12) begin
              buf_d[14]     = len_fill[63:32];
              buf_d[15]     = len_fill[31:0];
              last_d        = 1'b1;
              extra_d       = 1'b0;
              marker_done_d = 1'b0;
            end else begin
              last_d        = 1'b0;
              extra_d       = 1'b1;
              marker_done_d = (idx_q != 4'd15);
            end
          end else if (idx_q == 4'd15) begin
            idx_d   = '0;
            state_d = EMIT;
            last_d  = 1'b0;
            extra_d = 1'b0;
          end
        end
      end

      EMIT: begin
        if (bus.blk_ready) begin
          buf_d = '0;
          if (extra_q) begin
            state_d   = EMIT_EXTRA;
            buf_d[0]  = marker_done_q ? 32'h0 : MARKER;
            buf_d[14] = len_held[63:32];
            buf_d[15] = len_held[31:0];
            last_d    = 1'b1;
            extra_d   = 1'b0;
          end else if (last_q) begin
            state_d = FILL;
            cnt_d   = '0;
            idx_d   = '0;
            last_d  = 1'b0;
          end else begin
            state_d = FILL;
          end
        end
      end

      EMIT_EXTRA: begin
        if (bus.blk_ready) begin
          state_d       = FILL;
          buf_d         = '0;
          cnt_d         = '0;
          idx_d         = '0;
          last_d        = 1'b0;
          marker_done_d = 1'b0;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == FILL);
    bus.blk_valid = (state_q != FILL);
    bus.blk_last  = last_q;
    bus.blk_data  = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      bus.blk_data[511 - 32*i -: 32] = buf_q[i];
    end
  end

endmodule

// File: tb/tb_msg_block_packer.sv
// Scoreboard bench for msg_block_packer: padding reference model plus constant directed blocks.
module tb_msg_block_packer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  msg_block_packer_if bus();

  msg_block_packer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [511:0] d;
    logic         l;
  } blk_t;

  blk_t        exp_q[$];
  logic [31:0] msg[$];
  int          vectors = 0;
  int          errors  = 0;
  int          ready_mode = 0;
  bit          gaps = 1'b0;

  logic         prev_stall = 1'b0;
  logic [511:0] prev_d;
  logic         prev_l;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: append marker, zero-fill to 14 mod 16 words, append 64-bit bit length, cut into blocks.
  task automatic model_push();
    logic [31:0] p[$];
    logic [63:0] len;
    blk_t        b;
    int          nblk;
    p = msg;
    p.push_back(32'h8000_0000);
    while (p.size() % 16 != 14) p.push_back(32'h0);
    len = 64'(msg.size()) * 64'd32;
    p.push_back(len[63:32]);
    p.push_back(len[31:0]);
    nblk = p.size() / 16;
    for (int bi = 0; bi < nblk; bi++) begin
      b.d = '0;
      for (int j = 0; j < 16; j++) b.d[511 - 32*j -: 32] = p[bi*16 + j];
      b.l = (bi == nblk - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic drive_word(input logic [31:0] w, input logic l);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    bus.in_last  = l;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 500) begin
        vectors++;
        errors++;
        $display("FAIL in_accept_timeout: got no in_ready want in_ready within 500 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    bus.in_last  = 1'($urandom);
    if (gaps && ($urandom % 4 == 0)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drive_msg();
    for (int i = 0; i < msg.size(); i++) drive_word(msg[i], i == msg.size() - 1);
  endtask

  task automatic rand_msg(input int len);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back($urandom);
  endtask

  task automatic send_model_msg(input int len);
    rand_msg(len);
    model_push();
    drive_msg();
  endtask

  task automatic check_reset_state();
    check("rst_blk_valid", {511'b0, bus.blk_valid}, 512'd0);
    check("rst_blk_last",  {511'b0, bus.blk_last},  512'd0);
    check("rst_blk_data",  bus.blk_data,            512'd0);
    check("rst_in_ready",  {511'b0, bus.in_ready},  512'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL drain_timeout: got %0d blocks pending want 0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Consumer back-pressure: 0 always ready, 1 random, 2 stall 5 cycles per block, 3 never ready.
  initial begin
    int hold = 0;
    bus.blk_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: bus.blk_ready = 1'b1;
        1: bus.blk_ready = ($urandom % 3) != 0;
        2: begin
          if (bus.blk_valid && hold < 5) begin
            bus.blk_ready = 1'b0;
            hold++;
          end else begin
            bus.blk_ready = 1'b1;
            hold = 0;
          end
        end
        default: bus.blk_ready = 1'b0;
      endcase
    end
  end

  // Monitor: samples mid-cycle; a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    blk_t b;
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      check("in_ready_vs_blk_valid", {511'b0, bus.in_ready}, {511'b0, !bus.blk_valid});
      if (prev_stall) begin
        check("hold_blk_valid", {511'b0, bus.blk_valid}, 512'd1);
        check("hold_blk_data",  bus.blk_data, prev_d);
        check("hold_blk_last",  {511'b0, bus.blk_last}, {511'b0, prev_l});
      end
      if (bus.blk_valid && bus.blk_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_block: got block %h want none", bus.blk_data);
        end else begin
          b = exp_q.pop_front();
          check("blk_data", bus.blk_data, b.d);
          check("blk_last", {511'b0, bus.blk_last}, {511'b0, b.l});
        end
      end
      prev_stall = bus.blk_valid && !bus.blk_ready;
      prev_d     = bus.blk_data;
      prev_l     = bus.blk_last;
    end
  end

  initial begin
    blk_t b;
    int   lens[6] = '{1, 12, 13, 14, 15, 16};
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
    rst = 1'b1;

    // Single word "abc" message.
    b.d = '0;
    b.d[511:480] = 32'h6162_6300;
    b.d[479:448] = 32'h8000_0000;
    b.d[31:0]    = 32'h0000_0020;
    b.l = 1'b1;
    exp_q.push_back(b);
    drive_word(32'h6162_6300, 1'b1);

    // 80-byte header: two blocks, second carries length 640.
    rand_msg(20);
    b.d = '0;
    for (int j = 0; j < 16; j++) b.d[511 - 32*j -: 32] = msg[j];
    b.l = 1'b0;
    exp_q.push_back(b);
    b.d = '0;
    for (int j = 0; j < 4; j++) b.d[511 - 32*j -: 32] = msg[16 + j];
    b.d[383:352] = 32'h8000_0000;
    b.d[31:0]    = 32'h0000_0280;
    b.l = 1'b1;
    exp_q.push_back(b);
    drive_msg();

    // Boundary lengths back-to-back.
    foreach (lens[i]) send_model_msg(lens[i]);

    // Consumer stalls for 5 cycles on every block.
    ready_mode = 2;
    send_model_msg(16);
    send_model_msg(14);
    send_model_msg(5);

    // Random lengths with random back-pressure and input gaps.
    ready_mode = 1;
    gaps = 1'b1;
    for (int m = 0; m < 30; m++) send_model_msg(int'($urandom_range(1, 40)));
    gaps = 1'b0;
    wait_drain();

    // Reset part-way through a 7-word message: nothing emitted, next message restarts count.
    ready_mode = 0;
    for (int i = 0; i < 7; i++) drive_word($urandom, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
    rst = 1'b1;
    b.d = '0;
    b.d[511:480] = 32'h1234_5678;
    b.d[479:448] = 32'h8000_0000;
    b.d[31:0]    = 32'h0000_0020;
    b.l = 1'b1;
    exp_q.push_back(b);
    drive_word(32'h1234_5678, 1'b1);
    wait_drain();

    // Reset while a full block is pending in EMIT: it must be dropped.
    ready_mode = 3;
    for (int i = 0; i < 16; i++) drive_word($urandom, 1'b0);
    repeat (3) @(negedge clk);
    check("pending_blk_valid", {511'b0, bus.blk_valid}, 512'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    ready_mode = 0;
    @(posedge clk);
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
    rst = 1'b1;
    send_model_msg(3);
    wait_drain();

    @(negedge clk);
    check("idle_blk_valid", {511'b0, bus.blk_valid}, 512'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/msg_block_packer.md
MSG_BLOCK_PACKER -- requirements
Module: msg_block_packer

Interface
REQ-001 SHALL have no parameters; block width fixed at 512 bits (16 x 32-bit words), word width fixed at 32 bits.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-low.
REQ-004 in_valid  in  1  input word present.
REQ-005 in_data  in  32  message word, big-endian word order.
REQ-006 in_last  in  1  qualifies in_data as final word of message.
REQ-007 in_ready  out  1  packer accepts word this cycle.
REQ-008 blk_valid  out  1  padded 512-bit block available.
REQ-009 blk_data  out  512  block; word 0 in [511:480], word 15 in [31:0].
REQ-010 blk_last  out  1  block is final block of current message.
REQ-011 blk_ready  in  1  consumer accepts block this cycle.

Function
REQ-012 SHALL transfer a word only on in_valid & in_ready, and a block only on blk_valid & blk_ready.
REQ-013 SHALL use states FILL, EMIT, EMIT_EXTRA; in_ready = 1 only in FILL; blk_valid = 1 only in EMIT and EMIT_EXTRA.
REQ-014 FILL: accepted word SHALL be stored at word index idx (0..15), idx then increments; 32-bit word counter cnt increments per accepted word.
REQ-015 FILL, accepted word at idx 15 with in_last = 0 -> EMIT next cycle, blk_last = 0, idx reset to 0.
REQ-016 FILL, accepted last word at index k <= 12 -> same block gets word k+1 = 32'h80000000, words k+2..13 = 0, words 14..15 = 64-bit bit length; EMIT next cycle, blk_last = 1.
REQ-017 Bit length SHALL equal {27'b0, cnt_final, 5'b0}, cnt_final including the last word; cnt wraps modulo 2^32 without error.
REQ-018 Last word at k = 13 or 14 -> word k+1 = 32'h80000000, remaining words = 0; EMIT with blk_last = 0, then EMIT_EXTRA block: words 0..13 = 0, words 14..15 = length, blk_last = 1.
REQ-019 Last word at k = 15 -> EMIT block of 16 data words, blk_last = 0; EMIT_EXTRA block: word 0 = 32'h80000000, words 1..13 = 0, words 14..15 = length, blk_last = 1.
REQ-020 Latency: blk_valid SHALL assert the cycle after the accepting handshake of the completing word.
REQ-021 EMIT: blk_data, blk_last SHALL hold stable while blk_valid & !blk_ready; on handshake go to EMIT_EXTRA if REQ-018/019 applies, else FILL.
REQ-022 EMIT_EXTRA block SHALL be presented the cycle after the EMIT handshake; on its handshake -> FILL.
REQ-023 After a blk_last = 1 handshake, cnt and idx SHALL clear to 0 and the block buffer to all zeros before the next message.
REQ-024 in_data and in_last SHALL be ignored when in_ready = 0; no word is lost or duplicated across back-pressure.
REQ-025 Every message SHALL contain at least one word; a zero-length message cannot be expressed.
REQ-026 Consecutive messages SHALL be packed back-to-back with no idle cycle beyond REQ-020/022 latency.

Reset
REQ-027 While rst = 0 at a clock edge: state = FILL, idx = 0, cnt = 0, buffer = 0, in_ready = 1 from next cycle, blk_valid = 0, blk_last = 0, blk_data = 0.
REQ-028 Reset asserted mid-message or during EMIT/EMIT_EXTRA SHALL discard the partial message and pending block with no block emitted.

Verification
REQ-029 80-byte Bitcoin header (20 words, last on word 19), blk_ready = 1 -> block 1 = words 0..15, blk_last = 0; block 2 = words 16..19, 32'h80000000, zeros, word 15 = 32'h00000280, blk_last = 1.
REQ-030 Single word 32'h61626300 with in_last -> one block: word 0 = 32'h61626300, word 1 = 32'h80000000, word 15 = 32'h00000020, blk_last = 1.
REQ-031 14-word message -> block 1 word 14 = 32'h80000000, word 15 = 0, blk_last = 0; block 2 word 15 = 32'h000001C0, others 0, blk_last = 1.
REQ-032 16-word message -> full data block, blk_last = 0; block 2 word 0 = 32'h80000000, word 15 = 32'h00000200, blk_last = 1.
REQ-033 Hold blk_ready = 0 for 5 cycles in EMIT -> blk_data stable, in_ready = 0, in_valid words not consumed; release -> correct stream continues.
REQ-034 rst = 0 after 7 words of a message -> no block out; next 1-word message yields length 32'h00000020.
